multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Main control FSM for the RV32I multicycle datapath. Sequences fetch, decode, execute,
//  memory and writeback steps. Drives IRWrite, PCWrite, the register/memory write enables
//  and all datapath mux selects from state, opcode, the ALU Zero flag and memory readiness.
//  Sits beside the IR, PC, register file, ALU and unified memory.
// PARAMETERS
//  ILLEGAL_HALT  0   1: an undecoded opcode parks the FSM in HALT until reset; 0: return to FETCH
//  INSTRET_W     32  width of the retired-instruction counter (used only with MC_INSTRET_EN)
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   synchronous, active-high
//  opcode     in   7   inst[6:0] from IR
//  Zero       in   1   ALU zero flag
//  MemReady   in   1   memory has completed the current access this cycle
//  IRWrite    out  1   IR load enable
//  PCWrite    out  1   PCUpdate | (Branch & Zero)
//  AdrSrc     out  1   0: PC, 1: ALUOut
//  MemWrite   out  1   memory write strobe
//  RegWrite   out  1   register file write enable
//  ResultSrc  out  2   00: ALUOut, 01: Data, 10: ALUResult
//  ALUSrcA    out  2   00: PC, 01: OldPC, 10: rs1
//  ALUSrcB    out  2   00: rs2, 01: ImmExt, 10: 4
//  ALUOp      out  2   00: add, 01: sub, 10: funct-decoded
//  ImmSrc     out  2   combinational from opcode: I=00 (lw, OP-IMM), S=01, B=10, J=11, other=00
//  Illegal    out  1   1-cycle pulse in DECODE when the opcode is unknown
//  Halted     out  1   1 while in HALT
// BEHAVIOUR
//  - Moore outputs, decoded from state. Unlisted outputs are 0 in each state.
//  - While reset=1: next state is FETCH; IRWrite, PCWrite, MemWrite, RegWrite, Illegal and Halted are 0.
//  - Opcodes: lw 0000011, sw 0100011, R 0110011, OP-IMM 0010011, jal 1101111, beq 1100011.
//  - States and transitions (outputs listed per state):
//    FETCH    AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
//             IRWrite=PCWrite=MemReady.
//             Stay in FETCH while !MemReady; go to DECODE when MemReady.
//    DECODE   ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by opcode:
//             lw/sw -> MEMADR, R -> EXECR, OP-IMM -> EXECI, jal -> JAL, beq -> BEQ.
//             Any other opcode -> Illegal=1, then HALT if ILLEGAL_HALT else FETCH.
//    MEMADR   ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: lw -> MEMREAD, sw -> MEMWRITE.
//    MEMREAD  AdrSrc=1. Hold until MemReady, then -> MEMWB.
//    MEMWB    ResultSrc=01, RegWrite=1 -> FETCH.
//    MEMWRITE AdrSrc=1, MemWrite=1 held until MemReady, then -> FETCH.
//    EXECR    ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
//    EXECI    ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
//    JAL      ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 -> ALUWB.
//    ALUWB    ResultSrc=00, RegWrite=1 -> FETCH.
//    BEQ      ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero -> FETCH.
//    HALT     Halted=1, all enables 0. Exit only via reset.
//  - Cycles per instruction with MemReady tied to 1: beq 3; R, OP-IMM, jal and sw 4; lw 5.
//    Each cycle MemReady=0 in FETCH/MEMREAD/MEMWRITE adds one cycle.
//  - opcode is sampled only in DECODE and MEMADR. IR is stable there because IRWrite=0.
//  - Reset in any state, including mid-wait, returns to FETCH on the next edge
//    with no write enable asserted in that cycle.
//  - Unreachable state encodings recover to FETCH.
// CONFIGURATION
//  MC_INSTRET_EN defined:
//   - Adds output instret [INSTRET_W-1:0].
//   - Reset value 0. Increments by 1 on each retire transition into FETCH:
//     from MEMWB, ALUWB, BEQ, or MEMWRITE with MemReady.
//   - Wraps modulo 2^INSTRET_W. Illegal and HALT never increment it.
//  MC_INSTRET_EN undefined: no instret port and no counter logic.
// TESTING
//  1. reset=1 for 2 clk, then 0, MemReady=1, opcode=0110011
//     -> FETCH, DECODE, EXECR, ALUWB, FETCH; IRWrite=1 only in cycle 1; RegWrite=1 only in cycle 4.
//  2. opcode=0000011, MemReady low for 3 cycles in MEMREAD
//     -> MEMREAD held 4 cycles; AdrSrc=1 throughout; then MEMWB with RegWrite=1, ResultSrc=01.
//  3. opcode=1100011 with Zero=1, then repeat with Zero=0
//     -> PCWrite=1 in BEQ for the first; PCWrite=0 for the second; ALUOp=01 in both.
//  4. opcode=1111111 with ILLEGAL_HALT=0 and then =1
//     -> Illegal pulses 1 cycle; next state FETCH vs HALT (Halted=1 stuck until reset).
//  5. reset asserted in MEMWRITE while MemReady=0
//     -> MemWrite=0 on that cycle; FETCH on the next edge.
//  6. MC_INSTRET_EN, INSTRET_W=4, 17 back-to-back R-type instructions
//     -> instret reads 1 after wrapping.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_fsm
// Purpose  : Main control FSM for an RV32I multicycle datapath. Optional
//            retired-instruction counter enabled by defining MC_INSTRET_EN.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm #(
    parameter int ILLEGAL_HALT = 0,
    parameter int INSTRET_W    = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
    output logic       Illegal,
    output logic       Halted
`ifdef MC_INSTRET_EN
    ,
    output logic [INSTRET_W-1:0] instret
`endif
);

    localparam logic [6:0] c_OP_LW   = 7'b0000011;
    localparam logic [6:0] c_OP_SW   = 7'b0100011;
    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_IMM  = 7'b0010011;
    localparam logic [6:0] c_OP_JAL  = 7'b1101111;
    localparam logic [6:0] c_OP_BEQ  = 7'b1100011;

    localparam logic [3:0] c_FETCH    = 4'd0;
    localparam logic [3:0] c_DECODE   = 4'd1;
    localparam logic [3:0] c_MEMADR   = 4'd2;
    localparam logic [3:0] c_MEMREAD  = 4'd3;
    localparam logic [3:0] c_MEMWB    = 4'd4;
    localparam logic [3:0] c_MEMWRITE = 4'd5;
    localparam logic [3:0] c_EXECR    = 4'd6;
    localparam logic [3:0] c_EXECI    = 4'd7;
    localparam logic [3:0] c_JAL      = 4'd8;
    localparam logic [3:0] c_ALUWB    = 4'd9;
    localparam logic [3:0] c_BEQ      = 4'd10;
    localparam logic [3:0] c_HALT     = 4'd11;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_irwrite;
    logic       w_pcwrite;
    logic       w_memwrite;
    logic       w_regwrite;
    logic       w_illegal;
    logic       w_halted;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = c_FETCH;
        case (r_state)
            c_FETCH:    w_next = MemReady ? c_DECODE : c_FETCH;
            c_DECODE: begin
                case (opcode)
                    c_OP_LW, c_OP_SW: w_next = c_MEMADR;
                    c_OP_R:           w_next = c_EXECR;
                    c_OP_IMM:         w_next = c_EXECI;
                    c_OP_JAL:         w_next = c_JAL;
                    c_OP_BEQ:         w_next = c_BEQ;
                    default:          w_next = (ILLEGAL_HALT != 0) ? c_HALT : c_FETCH;
                endcase
            end
            c_MEMADR:   w_next = (opcode == c_OP_SW) ? c_MEMWRITE : c_MEMREAD;
            c_MEMREAD:  w_next = MemReady ? c_MEMWB : c_MEMREAD;
            c_MEMWB:    w_next = c_FETCH;
            c_MEMWRITE: w_next = MemReady ? c_FETCH : c_MEMWRITE;
            c_EXECR:    w_next = c_ALUWB;
            c_EXECI:    w_next = c_ALUWB;
            c_JAL:      w_next = c_ALUWB;
            c_ALUWB:    w_next = c_FETCH;
            c_BEQ:      w_next = c_FETCH;
            c_HALT:     w_next = c_HALT;
            default:    w_next = c_FETCH;
        endcase
    end

    always_comb begin
        w_irwrite  = 1'b0;
        w_pcwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        w_illegal  = 1'b0;
        w_halted   = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        case (r_state)
            c_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                w_irwrite = MemReady;
                w_pcwrite = MemReady;
            end
            c_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (opcode)
                    c_OP_LW, c_OP_SW, c_OP_R, c_OP_IMM, c_OP_JAL, c_OP_BEQ: w_illegal = 1'b0;
                    default: w_illegal = 1'b1;
                endcase
            end
            c_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            c_MEMREAD:  AdrSrc = 1'b1;
            c_MEMWB: begin
                ResultSrc  = 2'b01;
                w_regwrite = 1'b1;
            end
            c_MEMWRITE: begin
                AdrSrc     = 1'b1;
                w_memwrite = 1'b1;
            end
            c_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            c_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            c_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                w_pcwrite = 1'b1;
            end
            c_ALUWB:    w_regwrite = 1'b1;
            c_BEQ: begin
                ALUSrcA   = 2'b10;
                ALUOp     = 2'b01;
                w_pcwrite = Zero;
            end
            c_HALT:     w_halted = 1'b1;
            default: ;
        endcase
    end

    // Enables are masked by reset so a reset landing mid-access never writes.
    assign IRWrite  = w_irwrite  & ~reset;
    assign PCWrite  = w_pcwrite  & ~reset;
    assign MemWrite = w_memwrite & ~reset;
    assign RegWrite = w_regwrite & ~reset;
    assign Illegal  = w_illegal  & ~reset;
    assign Halted   = w_halted   & ~reset;

    always_comb begin
        case (opcode)
            c_OP_SW:  ImmSrc = 2'b01;
            c_OP_BEQ: ImmSrc = 2'b10;
            c_OP_JAL: ImmSrc = 2'b11;
            default:  ImmSrc = 2'b00;
        endcase
    end

`ifdef MC_INSTRET_EN
    logic w_retire;

    assign w_retire = (r_state == c_MEMWB) || (r_state == c_ALUWB) || (r_state == c_BEQ) ||
                      ((r_state == c_MEMWRITE) && MemReady);

    always_ff @(posedge clk) begin
        if (reset) begin
            instret <= '0;
        end else if (w_retire) begin
            instret <= instret + 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// Randomized scoreboard bench for multicycle_control_fsm: two instances
// (ILLEGAL_HALT=0 and =1) share stimulus; expectations come from per-instruction cycle tables.
module tb_multicycle_control_fsm;

    localparam int IW = 4;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RR  = 7'b0110011;
    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BEQ = 7'b1100011;

    typedef struct packed {
        logic       irw;
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       regw;
        logic [1:0] res;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] aop;
        logic [1:0] imm;
        logic       ill;
        logic       halt;
    } vec_t;

    typedef struct packed {
        vec_t        e0;
        vec_t        e1;
        logic [31:0] ret;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       Zero;
    logic       MemReady;

    logic       irw0, pcw0, adr0, memw0, regw0, ill0, hlt0;
    logic [1:0] res0, sa0, sb0, aop0, imm0;
    logic       irw1, pcw1, adr1, memw1, regw1, ill1, hlt1;
    logic [1:0] res1, sa1, sb1, aop1, imm1;
    vec_t       act0, act1;

    assign act0 = '{irw0, pcw0, adr0, memw0, regw0, res0, sa0, sb0, aop0, imm0, ill0, hlt0};
    assign act1 = '{irw1, pcw1, adr1, memw1, regw1, res1, sa1, sb1, aop1, imm1, ill1, hlt1};

`ifdef MC_INSTRET_EN
    logic [IW-1:0] ret0, ret1;
`endif

    multicycle_control_fsm #(.ILLEGAL_HALT(0), .INSTRET_W(IW)) u_dut0 (
        .clk(clk), .reset(reset), .opcode(opcode), .Zero(Zero), .MemReady(MemReady),
        .IRWrite(irw0), .PCWrite(pcw0), .AdrSrc(adr0), .MemWrite(memw0), .RegWrite(regw0),
        .ResultSrc(res0), .ALUSrcA(sa0), .ALUSrcB(sb0), .ALUOp(aop0), .ImmSrc(imm0),
        .Illegal(ill0), .Halted(hlt0)
`ifdef MC_INSTRET_EN
        , .instret(ret0)
`endif
    );

    multicycle_control_fsm #(.ILLEGAL_HALT(1), .INSTRET_W(IW)) u_dut1 (
        .clk(clk), .reset(reset), .opcode(opcode), .Zero(Zero), .MemReady(MemReady),
        .IRWrite(irw1), .PCWrite(pcw1), .AdrSrc(adr1), .MemWrite(memw1), .RegWrite(regw1),
        .ResultSrc(res1), .ALUSrcA(sa1), .ALUSrcB(sb1), .ALUOp(aop1), .ImmSrc(imm1),
        .Illegal(ill1), .Halted(hlt1)
`ifdef MC_INSTRET_EN
        , .instret(ret1)
`endif
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference-model state, tracked per instruction rather than per FSM state.
    logic halted1  = 1'b0;
    int   ret_cnt  = 0;
    int   step     = 0;
    int   abort_at = 0;
    logic aborted  = 1'b0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        case (op)
            SW:      return 2'b01;
            BEQ:     return 2'b10;
            JAL:     return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic vec_t mk(input logic irw, input logic pcw, input logic adr,
                                input logic memw, input logic regw, input logic [1:0] res,
                                input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] aop);
        vec_t v;
        v = '0;
        v.irw = irw; v.pcw = pcw; v.adr = adr; v.memw = memw; v.regw = regw;
        v.res = res; v.sa = sa; v.sb = sb; v.aop = aop;
        return v;
    endfunction

    function automatic vec_t gate(input vec_t v);
        vec_t g;
        g = v;
        g.irw = 1'b0; g.pcw = 1'b0; g.memw = 1'b0; g.regw = 1'b0; g.ill = 1'b0; g.halt = 1'b0;
        return g;
    endfunction

    task automatic check(input string name, input vec_t act, input vec_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // One clock of stimulus; pushes the expected outputs for that cycle.
    task automatic cyc(input logic mr, input logic z, input vec_t e, input logic retire,
                       input logic ill_halt);
        exp_t ex;
        vec_t v;
        logic rst_now;
        if (aborted) return;
        step++;
        rst_now  = (step == abort_at);
        reset    = rst_now;
        MemReady = mr;
        Zero     = z;
        v        = e;
        v.imm    = imm_of(opcode);
        ex.e0    = rst_now ? gate(v) : v;
        if (halted1) begin
            ex.e1      = '0;
            ex.e1.imm  = v.imm;
            ex.e1.halt = ~rst_now;
        end else begin
            ex.e1 = ex.e0;
        end
        ex.ret = 32'(ret_cnt);
        q.push_back(ex);
        @(posedge clk);
        #1;
        if (rst_now) begin
            aborted = 1'b1;
            ret_cnt = 0;
            halted1 = 1'b0;
        end else begin
            if (retire) ret_cnt++;
            if (ill_halt) halted1 = 1'b1;
        end
    endtask

    task automatic do_reset();
        aborted  = 1'b0;
        step     = 0;
        abort_at = 1;
        cyc(rb(), rb(), mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00), 1'b0, 1'b0);
        aborted  = 1'b0;
        abort_at = 0;
    endtask

    // zsel: 0/1 forces Zero in BEQ, anything else randomizes it. ab: cycle index to reset on.
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input int ab,
                             input int zsel);
        vec_t e;
        logic known;
        logic z;
        aborted  = 1'b0;
        step     = 0;
        abort_at = ab;
        opcode   = op;
        for (int i = 0; i < fw; i++)
            cyc(1'b0, rb(), mk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00), 1'b0, 1'b0);
        cyc(1'b1, rb(), mk(1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00), 1'b0, 1'b0);
        known = (op == LW) || (op == SW) || (op == RR) || (op == OPI) || (op == JAL) || (op == BEQ);
        e     = mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00);
        e.ill = ~known;
        cyc(rb(), rb(), e, 1'b0, ~known);
        if (op == LW || op == SW)
            cyc(rb(), rb(), mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00), 1'b0, 1'b0);
        case (op)
            LW: begin
                for (int i = 0; i < mw; i++)
                    cyc(1'b0, rb(), mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00), 1'b0, 1'b0);
                cyc(1'b1, rb(), mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00), 1'b0, 1'b0);
                cyc(rb(), rb(), mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00), 1'b1, 1'b0);
            end
            SW: begin
                for (int i = 0; i < mw; i++)
                    cyc(1'b0, rb(), mk(0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00), 1'b0, 1'b0);
                cyc(1'b1, rb(), mk(0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00), 1'b1, 1'b0);
            end
            RR, OPI, JAL: begin
                if (op == RR)
                    cyc(rb(), rb(), mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10), 1'b0, 1'b0);
                else if (op == OPI)
                    cyc(rb(), rb(), mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10), 1'b0, 1'b0);
                else
                    cyc(rb(), rb(), mk(0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00), 1'b0, 1'b0);
                cyc(rb(), rb(), mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00), 1'b1, 1'b0);
            end
            BEQ: begin
                z = (zsel == 0 || zsel == 1) ? 1'(zsel) : rb();
                cyc(rb(), z, mk(0, z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01), 1'b1, 1'b0);
            end
            default: ;
        endcase
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle.
    initial begin
        exp_t ex;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                ex = q.pop_front();
                check("dut0_outputs", act0, ex.e0);
                check("dut1_outputs", act1, ex.e1);
`ifdef MC_INSTRET_EN
                n_checks++;
                if (ret0 !== ex.ret[IW-1:0]) begin
                    n_fail++;
                    $display("FAIL instret t=%0t actual=%0d required=%0d", $time, ret0, ex.ret[IW-1:0]);
                end
`endif
            end
        end
    end

    initial begin
        logic [6:0] ops [6];
        logic [6:0] op;
        ops[0] = LW; ops[1] = SW; ops[2] = RR; ops[3] = OPI; ops[4] = JAL; ops[5] = BEQ;
        reset    = 1'b1;
        opcode   = RR;
        MemReady = 1'b1;
        Zero     = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        run_instr(RR, 0, 0, 0, 2);
        run_instr(LW, 0, 3, 0, 2);
        run_instr(BEQ, 0, 0, 0, 1);
        run_instr(BEQ, 0, 0, 0, 0);
        run_instr(7'b1111111, 0, 0, 0, 2);
        run_instr(OPI, 1, 0, 0, 2);
        run_instr(JAL, 0, 0, 0, 2);
        run_instr(SW, 0, 2, 4, 2);
        for (int i = 0; i < 17; i++) run_instr(RR, 0, 0, 0, 2);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) op = 7'($urandom);
            else                           op = ops[$urandom_range(0, 5)];
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3),
                      ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 7)) : 0, 2);
        end

        reset = 1'b0;
        repeat (2) @(posedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d required=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
